// File: rtl/elf_keypad.sv
// rtl/elf_keypad.sv - PS/2 key events to COSMAC ELF front-panel switches, IN button and hex byte entry
module elf_keypad #(
  parameter int               CNT_W         = 20,
  parameter logic [CNT_W-1:0] IN_MIN_CYCLES = 20'd50000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [10:0] ps2_key,
  input  logic        io_rd,
  output logic [7:0]  sw_data,
  output logic        byte_ready,
  output logic        in_n,
  output logic        run,
  output logic        load,
  output logic        mp
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} digit_state_t;

  digit_state_t     state_q, state_d;
  logic             tog_q;
  logic             armed_q;
  logic             in_held_q;
  logic [CNT_W-1:0] cnt_q;
  logic             hex_hit;
  logic [3:0]       nib;

  logic       ev, press_ev, rel_ev;
  logic [7:0] code;
  logic       hex_ev, bksp_ev, in_press, in_rel, run_ev, load_ev, mp_ev;

  // armed_q blocks decoding on the first clock after reset so a toggle that moved during reset is absorbed
  assign ev       = armed_q & (ps2_key[10] != tog_q) & ~ps2_key[8];
  assign press_ev = ev & ps2_key[9];
  assign rel_ev   = ev & ~ps2_key[9];
  assign code     = ps2_key[7:0];

  always_comb begin
    hex_hit = 1'b1;
    nib     = 4'h0;
    case (code)
      8'h45: nib = 4'h0;
      8'h16: nib = 4'h1;
      8'h1E: nib = 4'h2;
      8'h26: nib = 4'h3;
      8'h25: nib = 4'h4;
      8'h2E: nib = 4'h5;
      8'h36: nib = 4'h6;
      8'h3D: nib = 4'h7;
      8'h3E: nib = 4'h8;
      8'h46: nib = 4'h9;
      8'h1C: nib = 4'hA;
      8'h32: nib = 4'hB;
      8'h21: nib = 4'hC;
      8'h23: nib = 4'hD;
      8'h24: nib = 4'hE;
      8'h2B: nib = 4'hF;
      default: hex_hit = 1'b0;
    endcase
  end

  assign hex_ev   = press_ev & hex_hit;
  assign bksp_ev  = press_ev & (code == 8'h66);
  assign in_press = press_ev & (code == 8'h5A);
  assign in_rel   = rel_ev & (code == 8'h5A);
  assign run_ev   = press_ev & (code == 8'h2D);
  assign load_ev  = press_ev & (code == 8'h4B);
  assign mp_ev    = press_ev & (code == 8'h3A);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // A hex key takes priority over a simultaneous io_rd
  always_comb begin
    state_d = state_q;
    if (hex_ev) begin
      case (state_q)
        EMPTY:   state_d = ONE;
        ONE:     state_d = TWO;
        default: state_d = ONE;
      endcase
    end else if (bksp_ev || io_rd) begin
      state_d = EMPTY;
    end
  end

  always_comb begin
    byte_ready = (state_q == TWO);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tog_q   <= 1'b0;
      armed_q <= 1'b0;
      sw_data <= 8'h00;
    end else begin
      tog_q   <= ps2_key[10];
      armed_q <= 1'b1;
      if (hex_ev) begin
        sw_data <= {sw_data[3:0], nib};
      end else if (bksp_ev) begin
        sw_data <= 8'h00;
      end
    end
  end

  // in_n stays low until both the key is up and the minimum stretch has elapsed
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_n      <= 1'b1;
      in_held_q <= 1'b0;
      cnt_q     <= '0;
    end else if (in_press) begin
      in_n      <= 1'b0;
      in_held_q <= 1'b1;
      cnt_q     <= IN_MIN_CYCLES - 1'b1;
    end else begin
      if (cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (in_rel) begin
        in_held_q <= 1'b0;
      end
      if (!(in_held_q && !in_rel) && (cnt_q == '0)) begin
        in_n <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run  <= 1'b0;
      load <= 1'b0;
      mp   <= 1'b0;
    end else begin
      if (run_ev) begin
        run <= ~run;
        if (!run) begin
          load <= 1'b0;
        end
      end else if (load_ev) begin
        load <= ~load;
        if (!load) begin
          run <= 1'b0;
        end
      end
      if (mp_ev) begin
        mp <= ~mp;
      end
    end
  end

endmodule
